uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive controller that sequences the receive datapath.
- Generates the 16x oversample enable from a programmable divisor. This same pulse drives the stage-1 clock enable of the receive synchroniser.
- Detects and validates start bits, samples each bit at mid-bit, assembles 8-bit frames with optional parity, and checks the stop bit.
- Presents each received byte with status on a valid/ready holding register for the host-side FIFO or register interface.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- OS_RATE, 16, oversample ticks per bit. Fixed at 16; other values unsupported.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous reset, active-high.
- divisor_i  input  DIV_W  clocks per oversample tick; 0 disables the receiver.
- rxd_sync_i  input  1  synchronised serial data; idle level 1.
- parity_en_i  input  1  1 = a parity bit follows the data bits.
- parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- sample_en_o  output  1  one-cycle oversample tick; drives the synchroniser stage-1 enable.
- rx_data_o  output  8  received byte, LSB first on the line.
- rx_valid_o  output  1  holding register contains an unread byte.
- rx_ready_i  input  1  consumer accepts the byte.
- parity_err_o  output  1  parity mismatch for the byte in the holding register.
- framing_err_o  output  1  stop bit sampled as 0 for the byte in the holding register.
- overrun_o  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Clock/reset: single clock domain. Reset is synchronous and active-high on rst_i, sampled at the rising edge of clk_i.
- Reset values: all outputs 0. FSM in IDLE. Tick counter 0. armed = 0. A reset mid-frame aborts the frame and no partial data is delivered.
- Tick generator:
  - The down-counter reloads with divisor_i-1 when it reaches 0, and sample_en_o pulses in that cycle.
  - With divisor_i = 1, sample_en_o is asserted every cycle.
  - With divisor_i = 0: no ticks, counter held at 0, FSM forced to IDLE.
  - A divisor change takes effect at the next reload.
- All FSM activity occurs only in cycles where sample_en_o = 1. os_cnt is a 4-bit counter.
- Arming: on any tick with rxd_sync_i = 1, set armed = 1. A start bit is recognised only while armed = 1. This blocks repeated frames while the line is held low (break).
- IDLE: on a tick with rxd = 0 and armed = 1, go to START with os_cnt = 0.
- START:
  - os_cnt increments each tick.
  - On the tick where os_cnt = 7 (mid start bit):
    - if rxd = 1, treat as a glitch and return to IDLE;
    - otherwise set os_cnt = 0, bit_cnt = 0, latch parity_en_i and parity_odd_i, and go to DATA.
- DATA:
  - On the tick where os_cnt = 15, sample rxd and shift it in LSB first. bit_cnt increments; os_cnt wraps to 0.
  - After the 8th sample, go to PARITY if parity was latched enabled, else STOP.
- PARITY: sample at os_cnt = 15. par_err = (XOR of data bits XOR sampled bit) != odd. Then go to STOP.
- STOP: sample at os_cnt = 15, then go to IDLE immediately (mid-stop) and clear armed. The stop bit sampled as 1 re-arms on a later tick.
- Frame completion, in the clock after the stop-sample tick:
  - If rx_valid_o = 0, or rx_ready_i = 1 in the stop-sample cycle:
    - load rx_data_o, parity_err_o and framing_err_o (= !stop);
    - rx_valid_o = 1.
  - Otherwise the frame is discarded, the holding register is unchanged, and overrun_o pulses for 1 cycle.
- Handshake:
  - rx_valid_o clears the clock after a cycle with rx_valid_o = 1 and rx_ready_i = 1.
  - If a new load coincides with that cycle, the load wins and rx_valid_o stays 1.
  - rx_data_o and the error flags are stable while rx_valid_o = 1.
- Latency: rx_valid_o asserts 1 clock after the stop-sample tick. That is ~152 ticks (9.5 bit times, 8N1) after the start edge is detected.
- Parity enable and polarity are fixed per frame once START validates. Changing them mid-frame does not affect the current frame.

Test Plan:
- divisor=4, no parity, send 0xA5 8N1 at 64 clk/bit -> sample_en_o every 4 clk; rx_valid_o=1 with rx_data_o=0xA5 about 608 clk after the falling edge (±4); both error flags 0.
- divisor=4, rxd low for 16 clk then high -> START rejects at os_cnt 7; no rx_valid_o, FSM back in IDLE.
- parity_en=1, odd=0, send 0x03 with parity bit 1 -> rx_data_o=0x03, parity_err_o=1. Resend with parity bit 0 -> parity_err_o=0.
- Send 0x11 then 0x22 with rx_ready_i=0 throughout -> rx_data_o stays 0x11; overrun_o pulses exactly once. rx_ready_i=1 for 1 cycle -> rx_valid_o=0 next clock.
- Hold rxd low for 20 bit times, then high, then send 0x5A -> exactly one frame 0x00 with framing_err_o=1, followed only by 0x5A with no errors.
- divisor=0 -> sample_en_o never asserts and no frame is received. Assert rst_i mid-DATA -> all outputs 0 next clock; the following 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversample tick generator, start/data/parity/stop
// sequencing and a valid/ready holding register for the received byte.
module uart_rx_ctrl #(
  parameter int DIV_W   = 16,
  parameter int OS_RATE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] divisor_i,
  input  logic             rxd_sync_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  output logic             sample_en_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             parity_err_o,
  output logic             framing_err_o,
  output logic             overrun_o
);

  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
  localparam logic [3:0] OS_MID  = 4'(OS_RATE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] tick_cnt;
  logic [3:0]       os_cnt, os_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             par_en, par_en_nxt;
  logic             par_odd, par_odd_nxt;
  logic             par_err, par_err_nxt;
  logic             armed, armed_nxt;
  logic             frame_done;
  logic             rx_off;

  function automatic logic parity_mismatch(input logic [7:0] data, input logic bit_in,
                                           input logic odd);
    return ((^data) ^ bit_in) != odd;
  endfunction

  assign rx_off = (divisor_i == '0);

  // Tick generator: sample_en_o is registered so it is 0 straight out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || rx_off) begin
      tick_cnt    <= '0;
      sample_en_o <= 1'b0;
    end else if (tick_cnt == '0) begin
      tick_cnt    <= divisor_i - DIV_W'(1);
      sample_en_o <= 1'b1;
    end else begin
      tick_cnt    <= tick_cnt - DIV_W'(1);
      sample_en_o <= 1'b0;
    end
  end

  // Frame sequencer: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_en  <= par_en_nxt;
      par_odd <= par_odd_nxt;
      armed   <= armed_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    shift   <= shift_nxt;
    par_err <= par_err_nxt;
  end

  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_en_nxt  = par_en;
    par_odd_nxt = par_odd;
    par_err_nxt = par_err;
    armed_nxt   = armed;
    frame_done  = 1'b0;
    if (rx_off) begin
      state_nxt = IDLE;
    end else if (sample_en_o) begin
      if (rxd_sync_i) armed_nxt = 1'b1;
      case (state)
        IDLE: begin
          if (!rxd_sync_i && armed) begin
            state_nxt  = START;
            os_cnt_nxt = '0;
          end
        end
        START: begin
          if (os_cnt == OS_MID) begin
            if (rxd_sync_i) begin
              state_nxt = IDLE;
            end else begin
              state_nxt   = DATA;
              os_cnt_nxt  = '0;
              bit_cnt_nxt = '0;
              par_en_nxt  = parity_en_i;
              par_odd_nxt = parity_odd_i;
              par_err_nxt = 1'b0;
            end
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            shift_nxt   = {rxd_sync_i, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
            os_cnt_nxt  = '0;
            if (bit_cnt == 3'd7) state_nxt = par_en ? PARITY : STOP;
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (os_cnt == OS_LAST) begin
            par_err_nxt = parity_mismatch(shift, rxd_sync_i, par_odd);
            os_cnt_nxt  = '0;
            state_nxt   = STOP;
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            // Leaving at mid-stop; disarming blocks re-triggering on a held-low break.
            frame_done = 1'b1;
            armed_nxt  = 1'b0;
            os_cnt_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Holding register: a new load takes priority over the handshake clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_o    <= 1'b0;
      rx_data_o     <= '0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o     <= shift;
          parity_err_o  <= par_err;
          framing_err_o <= ~rxd_sync_i;
          rx_valid_o    <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: drives serial frames at 64 clk/bit and compares
// received bytes against a frame-level reference model.
module tb_uart_rx_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] divisor = 16'd4;
  logic        rxd = 1'b1;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rx_ready = 1'b0;
  logic        sample_en, rx_valid, parity_err, framing_err, overrun;
  logic [7:0]  rx_data;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  frame_t got_q[$];
  int     ovr_seen = 0;
  int     ticks_seen = 0;
  logic   valid_prev = 1'b0;

  uart_rx_ctrl #(.DIV_W(16), .OS_RATE(16)) dut (
    .clk_i(clk), .rst_i(rst), .divisor_i(divisor), .rxd_sync_i(rxd),
    .parity_en_i(parity_en), .parity_odd_i(parity_odd), .sample_en_o(sample_en),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .parity_err_o(parity_err), .framing_err_o(framing_err), .overrun_o(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records each byte loaded into the holding register, overrun pulses and ticks.
  always begin
    @(posedge clk);
    #1;
    if (rx_valid && (!valid_prev || rx_ready))
      got_q.push_back('{data: rx_data, perr: parity_err, ferr: framing_err, at: cyc});
    if (overrun) ovr_seen++;
    if (sample_en) ticks_seen++;
    valid_prev = rx_valid;
  end

  function automatic frame_t model(input logic [7:0] d, input logic pen, input logic podd,
                                   input logic pbit, input logic stopb);
    frame_t f;
    int ones;
    ones   = $countones(d) + ((pen && pbit) ? 1 : 0);
    f.data = d;
    f.perr = pen && (podd ? (ones % 2 == 0) : (ones % 2 == 1));
    f.ferr = !stopb;
    f.at   = 0;
    return f;
  endfunction

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_bit(input logic v);
    rxd = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb, output int edge_at);
    edge_at = cyc + 1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (pen) hold_bit(pbit);
    hold_bit(stopb);
    rxd = 1'b1;
  endtask

  task automatic consume;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++; if (sample_en !== 1'b0) begin mismatched++; $display("FAIL reset_sample_en: got %b want 0", sample_en); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", rx_data); end
    compared++; if (parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    compared++; if (framing_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b want 0", framing_err); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    idle(32);
  endtask

  task automatic test_tick;
    int b;
    int d;
    b = ticks_seen;
    repeat (40) @(negedge clk);
    compared++; if (ticks_seen - b !== 10) begin mismatched++; $display("FAIL tick_div4: got %0d want 10", ticks_seen - b); end
    divisor = 16'd1;
    repeat (8) @(negedge clk);
    b = ticks_seen;
    repeat (20) @(negedge clk);
    compared++; if (ticks_seen - b !== 20) begin mismatched++; $display("FAIL tick_div1: got %0d want 20", ticks_seen - b); end
    d = int'($urandom_range(9, 2));
    divisor = 16'(d);
    repeat (16) @(negedge clk);
    b = ticks_seen;
    repeat (10 * d) @(negedge clk);
    compared++; if (ticks_seen - b !== 10) begin mismatched++; $display("FAIL tick_div%0d: got %0d want 10", d, ticks_seen - b); end
    divisor = 16'd4;
    idle(32);
  endtask

  task automatic test_basic;
    int base, edge_at, lat;
    frame_t exp;
    parity_en = 1'b0;
    base = got_q.size();
    exp = model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, edge_at);
    compared++;
    if (got_q.size() !== base + 1) begin
      mismatched++; $display("FAIL basic_count: got %0d want 1", got_q.size() - base);
    end else begin
      lat = got_q[base].at - edge_at;
      compared++; if (got_q[base].data !== exp.data) begin mismatched++; $display("FAIL basic_data: got %h want %h", got_q[base].data, exp.data); end
      compared++; if (got_q[base].perr !== 1'b0 || got_q[base].ferr !== 1'b0) begin mismatched++; $display("FAIL basic_flags: got p%b f%b want p0 f0", got_q[base].perr, got_q[base].ferr); end
      compared++; if (lat < 604 || lat > 612) begin mismatched++; $display("FAIL basic_latency: got %0d want 608+-4", lat); end
    end
    idle(32);
    compared++; if (rx_valid !== 1'b1) begin mismatched++; $display("FAIL basic_hold: got %b want 1", rx_valid); end
    consume;
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL basic_release: got %b want 0", rx_valid); end
  endtask

  task automatic test_parity;
    int base, edge_at;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic pbit;
      pbit = (k == 0);
      base = got_q.size();
      send_frame(8'h03, 1'b1, pbit, 1'b1, edge_at);
      idle(32);
      compared++;
      if (got_q.size() !== base + 1) begin
        mismatched++; $display("FAIL parity_count%0d: got %0d want 1", k, got_q.size() - base);
      end else begin
        compared++; if (got_q[base].data !== 8'h03) begin mismatched++; $display("FAIL parity_data%0d: got %h want 03", k, got_q[base].data); end
        compared++; if (got_q[base].perr !== pbit) begin mismatched++; $display("FAIL parity_err%0d: got %b want %b", k, got_q[base].perr, pbit); end
      end
      consume;
    end
    parity_en = 1'b0;
  endtask

  task automatic test_random;
    int base, edge_at;
    frame_t exp;
    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      logic pen, podd, pbit;
      d = 8'($urandom);
      pen = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      parity_en = pen;
      parity_odd = podd;
      exp = model(d, pen, podd, pbit, 1'b1);
      base = got_q.size();
      send_frame(d, pen, pbit, 1'b1, edge_at);
      parity_en = ~pen;
      parity_odd = ~podd;
      idle(32);
      compared++;
      if (got_q.size() !== base + 1) begin
        mismatched++; $display("FAIL rand_count%0d: got %0d want 1", n, got_q.size() - base);
      end else begin
        compared++;
        if (got_q[base].data !== exp.data || got_q[base].perr !== exp.perr || got_q[base].ferr !== exp.ferr) begin
          mismatched++;
          $display("FAIL rand_frame%0d: got %h p%b f%b want %h p%b f%b", n, got_q[base].data,
                   got_q[base].perr, got_q[base].ferr, exp.data, exp.perr, exp.ferr);
        end
      end
      consume;
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  task automatic test_glitch;
    int base, edge_at;
    base = got_q.size();
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    idle(800);
    compared++; if (got_q.size() !== base) begin mismatched++; $display("FAIL glitch_frames: got %0d want 0", got_q.size() - base); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, edge_at);
    idle(32);
    compared++;
    if (got_q.size() !== base + 1) begin
      mismatched++; $display("FAIL glitch_after_count: got %0d want 1", got_q.size() - base);
    end else if (got_q[base].data !== 8'hC3) begin
      mismatched++; $display("FAIL glitch_after_data: got %h want c3", got_q[base].data);
    end
    consume;
  endtask

  task automatic test_overrun;
    int base, ob, edge_at;
    base = got_q.size();
    ob = ovr_seen;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, edge_at);
    idle(32);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, edge_at);
    idle(32);
    compared++; if (got_q.size() !== base + 1) begin mismatched++; $display("FAIL ovr_loads: got %0d want 1", got_q.size() - base); end
    compared++; if (rx_data !== 8'h11) begin mismatched++; $display("FAIL ovr_data: got %h want 11", rx_data); end
    compared++; if (ovr_seen - ob !== 1) begin mismatched++; $display("FAIL ovr_pulses: got %0d want 1", ovr_seen - ob); end
    compared++; if (rx_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    consume;
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_release: got %b want 0", rx_valid); end
  endtask

  task automatic test_break;
    int base, edge_at;
    frame_t exp;
    exp = model(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    base = got_q.size();
    rx_ready = 1'b1;
    rxd = 1'b0;
    repeat (1280) @(negedge clk);
    idle(128);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, edge_at);
    idle(64);
    rx_ready = 1'b0;
    compared++;
    if (got_q.size() !== base + 2) begin
      mismatched++; $display("FAIL break_count: got %0d want 2", got_q.size() - base);
    end else begin
      compared++;
      if (got_q[base].data !== 8'h00 || got_q[base].ferr !== 1'b1 || got_q[base].perr !== 1'b0) begin
        mismatched++; $display("FAIL break_frame: got %h f%b p%b want 00 f1 p0", got_q[base].data, got_q[base].ferr, got_q[base].perr);
      end
      compared++;
      if (got_q[base+1].data !== exp.data || got_q[base+1].ferr !== exp.ferr || got_q[base+1].perr !== exp.perr) begin
        mismatched++; $display("FAIL break_next: got %h f%b p%b want %h f0 p0", got_q[base+1].data, got_q[base+1].ferr, got_q[base+1].perr, exp.data);
      end
    end
  endtask

  task automatic test_div0;
    int base, tb0, edge_at;
    divisor = 16'd0;
    repeat (8) @(negedge clk);
    base = got_q.size();
    tb0 = ticks_seen;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, edge_at);
    idle(64);
    compared++; if (ticks_seen - tb0 !== 0) begin mismatched++; $display("FAIL div0_ticks: got %0d want 0", ticks_seen - tb0); end
    compared++; if (got_q.size() !== base) begin mismatched++; $display("FAIL div0_frames: got %0d want 0", got_q.size() - base); end
    divisor = 16'd4;
    idle(32);
  endtask

  task automatic test_reset_mid;
    int base, edge_at;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, edge_at);
    idle(32);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || parity_err !== 1'b0 || framing_err !== 1'b0 ||
        overrun !== 1'b0 || sample_en !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got v%b d%h p%b f%b o%b s%b want all 0", rx_valid, rx_data,
               parity_err, framing_err, overrun, sample_en);
    end
    rst = 1'b0;
    base = got_q.size();
    idle(700);
    compared++; if (got_q.size() !== base) begin mismatched++; $display("FAIL midreset_partial: got %0d want 0", got_q.size() - base); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, edge_at);
    idle(32);
    compared++;
    if (got_q.size() !== base + 1) begin
      mismatched++; $display("FAIL midreset_after_count: got %0d want 1", got_q.size() - base);
    end else if (got_q[base].data !== 8'h3C || got_q[base].perr !== 1'b0 || got_q[base].ferr !== 1'b0) begin
      mismatched++; $display("FAIL midreset_after_frame: got %h p%b f%b want 3c p0 f0", got_q[base].data, got_q[base].perr, got_q[base].ferr);
    end
    consume;
  endtask

  initial begin
    test_reset;
    test_tick;
    test_basic;
    test_parity;
    test_random;
    test_glitch;
    test_overrun;
    test_break;
    test_div0;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
